// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program-image loader.
package prog_loader_pkg;

  localparam int unsigned WORD_W  = 14;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned N_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_t;

  // Instruction word layout of the loaded program image
  localparam int unsigned OPC_MSB = 13;
  localparam int unsigned OPC_LSB = 10;
  localparam int unsigned ARG_MSB = 9;
  localparam int unsigned ARG_LSB = 0;

endpackage

// File: rtl/loader_shift.sv
// Serial-to-parallel word assembler: MSB-first shift register, bit counter,
// and a word-complete flag raised on the edge that accepts the last bit.
module loader_shift
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W = prog_loader_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              sdata,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  // The final bit of a word comes straight from sdata, so only WORD_W-1 bits are stored
  logic [WORD_W-2:0] sr;
  logic [CNT_W-1:0]  cnt;

  assign word      = {sr, sdata};
  assign word_done = en && (cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      sr  <= word[WORD_W-2:0];
      cnt <= word_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: writes N_WORDS words into program memory while holding the CPU.
// Optional trailing checksum word enabled by macro PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_W  = prog_loader_pkg::WORD_W,
  parameter int unsigned ADDR_W  = prog_loader_pkg::ADDR_W,
  parameter int unsigned N_WORDS = prog_loader_pkg::N_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sdata,
  input  logic              svalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic              shift_en;
  logic              shift_clr;

  assign shift_en  = svalid && ((state == LOAD) || (state == CHECK));
  assign shift_clr = start && ((state == IDLE) || (state == DONE));

  loader_shift #(
    .WORD_W(WORD_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (shift_clr),
    .en       (shift_en),
    .sdata    (sdata),
    .word     (word),
    .word_done(word_done)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      waddr    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum      <= '0;
      error    <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            waddr    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= '0;
            error    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (word_done) begin
            mem_we   <= 1'b1;
            mem_din  <= word;
            mem_addr <= waddr;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= sum + word;
`endif
            // Address saturates on the last word so mem_addr never wraps within a load
            if (waddr == ADDR_W'(N_WORDS - 1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state    <= CHECK;
`else
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              waddr <= waddr + 1'b1;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (word_done) begin
            error    <= (word != sum);
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default build and PROG_LOADER_CHECKSUM_EN build).
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned W  = 14;
  localparam int unsigned AW = 5;
  localparam int unsigned NW = 16;

  logic          clk = 1'b0;
  logic          rst, start, sdata, svalid;
  logic          mem_we, cpu_hold, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_din;

  prog_loader #(
    .WORD_W (W),
    .ADDR_W (AW),
    .N_WORDS(NW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sdata   (sdata),
    .svalid  (svalid),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  int           we_count    = 0;
  int           addr_log[$];
  logic [W-1:0] tbmem[0:NW-1];
  logic [W-1:0] exp_data[0:NW-1];
  logic [W-1:0] exp_sum;

  // Memory model behind the external write port
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      addr_log.push_back(int'(mem_addr));
      if (int'(mem_addr) < int'(NW)) tbmem[int'(mem_addr)] = mem_din;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    we_count = 0;
    addr_log.delete();
    exp_sum = '0;
    for (int i = 0; i < int'(NW); i++) tbmem[i] = '0;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    @(negedge clk);
    sdata  = b;
    svalid = 1'b1;
    if (gap) begin
      @(negedge clk);
      svalid = 1'b0;
      sdata  = ~b;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gap);
    for (int i = int'(W) - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      svalid = 1'b0;
      sdata  = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    svalid = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic finish_load(input logic [W-1:0] ck);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(ck, 1'b0);
`else
    if (ck === 'x) $display("checksum word unused");
`endif
    idle(3);
  endtask

  initial begin
    logic [W-1:0] w;
    rst = 1'b1; start = 1'b0; sdata = 1'b0; svalid = 1'b0;
    clear_sb();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din",  32'(mem_din),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b0;
    idle(3);
    check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    check("idle_state",    32'(dut.state), 32'(IDLE));

    // 16 words 0..15 at continuous svalid
    clear_sb();
    pulse_start();
    check("a_busy",     32'(busy),     32'd1);
    check("a_cpu_hold", 32'(cpu_hold), 32'd1);
    for (int k = 0; k < int'(NW); k++) begin
      w = W'(k);
      send_word(w, 1'b0);
      exp_sum = exp_sum + w;
    end
    finish_load(exp_sum);
    check("a_we_count", 32'(we_count), 32'd16);
    for (int k = 0; k < int'(NW); k++) begin
      check("a_addr", 32'(addr_log[k]), 32'(k));
      check("a_data", 32'(tbmem[k]),    32'(k));
    end
    check("a_done",      32'(done),     32'd1);
    check("a_cpu_hold0", 32'(cpu_hold), 32'd0);
    check("a_busy0",     32'(busy),     32'd0);
    check("a_error",     32'(error),    32'd0);
    check("a_we_idle",   32'(mem_we),   32'd0);
    check("a_addr_hold", 32'(mem_addr), 32'd15);
    check("a_din_hold",  32'(mem_din),  32'd15);

    // Restart from DONE; word 0x2A5C with svalid toggling every cycle
    clear_sb();
    pulse_start();
    check("b_done_clr", 32'(done),     32'd0);
    check("b_busy",     32'(busy),     32'd1);
    check("b_cpu_hold", 32'(cpu_hold), 32'd1);
    w = 14'h2A5C;
    exp_data[0] = w;
    for (int i = int'(W) - 1; i >= 1; i--) send_bit(w[i], 1'b1);
    check("b_no_we_early", 32'(we_count), 32'd0);
    check("b_we_low",      32'(mem_we),   32'd0);
    send_bit(w[0], 1'b1);
    check("b_we_pulse", 32'(mem_we),   32'd1);
    check("b_addr",     32'(mem_addr), 32'd0);
    check("b_din",      32'(mem_din),  32'h2A5C);
    idle(2);
    check("b_we_once",  32'(we_count), 32'd1);
    check("b_we_low2",  32'(mem_we),   32'd0);
    check("b_din_hold", 32'(mem_din),  32'h2A5C);
    exp_sum = w;

    // Remaining words, with a start pulse in the middle of word 3
    for (int k = 1; k < int'(NW); k++) begin
      w = W'(k * 291 + 5);
      exp_data[k] = w;
      for (int i = int'(W) - 1; i >= 0; i--) begin
        if (k == 3 && i == 6) pulse_start();
        send_bit(w[i], 1'b0);
      end
      exp_sum = exp_sum + w;
    end
    finish_load(exp_sum);
    check("c_we_count", 32'(we_count), 32'd16);
    for (int k = 0; k < int'(NW); k++) begin
      check("c_addr", 32'(addr_log[k]), 32'(k));
      check("c_data", 32'(tbmem[k]),    32'(exp_data[k]));
    end
    check("c_done",  32'(done),  32'd1);
    check("c_error", 32'(error), 32'd0);

    // Reset mid-load after 5 words
    clear_sb();
    pulse_start();
    for (int k = 0; k < 5; k++) send_word(W'(k * 273 + 1), 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("d_we_count5", 32'(we_count), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("d_mem_we",   32'(mem_we),    32'd0);
    check("d_state",    32'(dut.state), 32'(IDLE));
    check("d_cpu_hold", 32'(cpu_hold),  32'd1);
    check("d_done",     32'(done),      32'd0);
    check("d_busy",     32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      svalid = 1'b1;
      sdata  = i[0];
    end
    idle(2);
    check("d_no_more_we", 32'(we_count), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("d_addr", 32'(addr_log[k]), 32'(k));
      check("d_kept", 32'(tbmem[k]),    32'(W'(k * 273 + 1)));
    end
    check("d_cpu_hold2", 32'(cpu_hold), 32'd1);
    check("d_done2",     32'(done),     32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Matching checksum
    clear_sb();
    pulse_start();
    for (int k = 0; k < int'(NW); k++) send_word(14'h0001, 1'b0);
    w = 14'h0010;
    send_word(w, 1'b0);
    idle(3);
    check("e_error",    32'(error),    32'd0);
    check("e_done",     32'(done),     32'd1);
    check("e_we_count", 32'(we_count), 32'd16);

    // Mismatching checksum
    clear_sb();
    pulse_start();
    check("f_error_clr", 32'(error), 32'd0);
    for (int k = 0; k < int'(NW); k++) send_word(14'h0001, 1'b0);
    w = 14'h0011;
    send_word(w, 1'b0);
    idle(3);
    check("f_error",    32'(error),    32'd1);
    check("f_done",     32'(done),     32'd1);
    check("f_we_count", 32'(we_count), 32'd16);
    check("f_cpu_hold", 32'(cpu_hold), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
